chip8_reg_transfer: RTL and testbench

CHIP8_REG_TRANSFER -- requirements
Module: chip8_reg_transfer

---
 rtl/chip8_reg_transfer.sv | 185 ++++++++++++++++++
 tb/tb_chip8_reg_transfer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_reg_transfer.sv
// -----------------------------------------------------------------------------
// chip8_reg_transfer
//
// Sequences the CHIP-8 block register transfers between the V register file
// and main memory:
//   Fx55 (dir=0): store V0..Vx to memory at I..I+x
//   Fx65 (dir=1): load  V0..Vx from memory at I..I+x
// Memory reads have one cycle of latency. A load therefore pipelines: the read
// issued for index k is written back to the register file one cycle later. A
// final LOAD_DRAIN cycle writes the last register.
//
// Ports
//   cpu_clk        single clock, rising-edge
//   reset_n        asynchronous active-low reset
//   start          one-cycle request, only honoured in IDLE
//   dir            0 = store, 1 = load (sampled with start)
//   last_reg[3:0]  x, the highest register index transferred (sampled with start)
//   base_addr[11:0] I register value (sampled with start)
//   busy           high in STORE, LOAD and LOAD_DRAIN
//   done           one-cycle completion pulse (DONE state)
//   reg_addr/reg_writedata/reg_WE   register-file write port and read address
//   reg_readdata   combinational register-file read data for reg_addr
//   mem_addr/mem_writedata/mem_WE   memory port
//   mem_readdata   memory read data, valid one cycle after mem_addr
//
// Configuration
//   CHIP8_I_INCREMENT_EN  when defined, adds i_update / i_new[11:0]. In the
//                         DONE cycle these report I' = (I + x + 1) mod 4096.
//                         Without the macro the ports do not exist and I is
//                         left untouched.
// -----------------------------------------------------------------------------
module chip8_reg_transfer (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dir,
  input  logic [3:0]  last_reg,
  input  logic [11:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_writedata,
  output logic        reg_WE,
  input  logic [7:0]  reg_readdata,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_writedata,
  output logic        mem_WE,
  input  logic [7:0]  mem_readdata
`ifdef CHIP8_I_INCREMENT_EN
  ,
  output logic        i_update,
  output logic [11:0] i_new
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_LOAD_DRAIN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;        // current transfer index
  logic [3:0]  x_q, x_d;        // latched last register index
  logic [11:0] base_q, base_d;  // latched I value

  // 12-bit address arithmetic; the carry out is discarded so I+k wraps.
  logic [11:0] addr_k;
  assign addr_k = base_q + {8'd0, k_q};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      x_q     <= 4'd0;
      base_q  <= 12'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      base_q  <= base_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    base_d  = base_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = last_reg;
          base_d  = base_addr;
          k_d     = 4'd0;
          state_d = dir ? S_LOAD : S_STORE;
        end
      end
      S_STORE: begin
        k_d = k_q + 4'd1;
        if (k_q == x_q) begin
          k_d     = 4'd0;
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        k_d = k_q + 4'd1;
        if (k_q == x_q) begin
          k_d     = 4'd0;
          state_d = S_LOAD_DRAIN;
        end
      end
      S_LOAD_DRAIN: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: purely a function of state, so reset clears them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    reg_addr      = 4'd0;
    reg_writedata = 8'd0;
    reg_WE        = 1'b0;
    mem_addr      = 12'd0;
    mem_writedata = 8'd0;
    mem_WE        = 1'b0;

    unique case (state_q)
      S_STORE: begin
        busy          = 1'b1;
        reg_addr      = k_q;
        mem_addr      = addr_k;
        mem_writedata = reg_readdata;
        mem_WE        = 1'b1;
      end
      S_LOAD: begin
        busy     = 1'b1;
        mem_addr = addr_k;
        // Data for index k-1 returns this cycle; index 0 has nothing pending.
        if (k_q != 4'd0) begin
          reg_WE        = 1'b1;
          reg_addr      = k_q - 4'd1;
          reg_writedata = mem_readdata;
        end
      end
      S_LOAD_DRAIN: begin
        busy          = 1'b1;
        reg_WE        = 1'b1;
        reg_addr      = x_q;
        reg_writedata = mem_readdata;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef CHIP8_I_INCREMENT_EN
  always_comb begin
    i_update = 1'b0;
    i_new    = 12'd0;
    if (state_q == S_DONE) begin
      i_update = 1'b1;
      i_new    = base_q + {8'd0, x_q} + 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chip8_reg_transfer.sv
// -----------------------------------------------------------------------------
// tb_chip8_reg_transfer
//
// Self-checking bench for chip8_reg_transfer. The bench holds a register file
// and a memory with one cycle of read latency, and keeps a separate reference
// image of both. The reference applies each transfer as a whole:
// mem[(I+k) mod 4096] <-> V[k] for k = 0..x. The expected per-cycle port
// activity comes from the cycle timing of stores and loads.
// Define CHIP8_I_INCREMENT_EN for both files to exercise the I update outputs.
// -----------------------------------------------------------------------------
module tb_chip8_reg_transfer;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        dir;
  logic [3:0]  last_reg;
  logic [11:0] base_addr;
  logic        busy, done;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_writedata;
  logic        reg_WE;
  logic [7:0]  reg_readdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_writedata;
  logic        mem_WE;
  logic [7:0]  mem_readdata;
`ifdef CHIP8_I_INCREMENT_EN
  logic        i_update;
  logic [11:0] i_new;
`endif

  chip8_reg_transfer dut (
    .cpu_clk       (cpu_clk),
    .reset_n       (reset_n),
    .start         (start),
    .dir           (dir),
    .last_reg      (last_reg),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .reg_addr      (reg_addr),
    .reg_writedata (reg_writedata),
    .reg_WE        (reg_WE),
    .reg_readdata  (reg_readdata),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_WE        (mem_WE),
    .mem_readdata  (mem_readdata)
`ifdef CHIP8_I_INCREMENT_EN
    ,
    .i_update      (i_update),
    .i_new         (i_new)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  // ---------------------------------------------------------------------------
  // Register file and memory attached to the DUT, preloaded from images.
  // ---------------------------------------------------------------------------
  logic [7:0] regs    [16];
  logic [7:0] mem     [4096];
  logic [7:0] img_regs[16];
  logic [7:0] img_mem [4096];
  logic [7:0] mem_rd_q;
  logic       load_img;

  assign reg_readdata = regs[reg_addr];
  assign mem_readdata = mem_rd_q;

  always @(posedge cpu_clk) begin
    mem_rd_q <= mem[mem_addr];
    if (load_img) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img_mem[i];
      for (int i = 0; i < 16; i++) regs[i] <= img_regs[i];
    end else begin
      if (mem_WE) mem[mem_addr] <= mem_writedata;
      if (reg_WE) regs[reg_addr] <= reg_writedata;
    end
  end

  // Reference images.
  logic [7:0] exp_regs[16];
  logic [7:0] exp_mem [4096];

  int vectors    = 0;
  int miscompares = 0;

  // Field masks within the packed port bus.
  localparam logic [63:0] M_RA = 64'h0000_0000_F000_0000;
  localparam logic [63:0] M_RD = 64'h0000_0000_0FF0_0000;
  localparam logic [63:0] M_MA = 64'h0000_0000_000F_FF00;
  localparam logic [63:0] M_MD = 64'h0000_0000_0000_00FF;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] addr(input logic [11:0] b, input int k);
    return 12'((int'(b) + k) % 4096);
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic d,
                                       input logic rw, input logic mw,
                                       input logic [3:0] ra, input logic [7:0] rd,
                                       input logic [11:0] ma, input logic [7:0] md);
    return {28'd0, b, d, rw, mw, ra, rd, ma, md};
  endfunction

  function automatic logic [63:0] dut_bus();
    return pack(busy, done, reg_WE, mem_WE, reg_addr, reg_writedata,
                mem_addr, mem_writedata);
  endfunction

  task automatic compare_images(input string name);
    int rerr = 0;
    int merr = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== exp_regs[i]) rerr++;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) merr++;
    check({name, " regs_image"}, 64'(rerr), 64'd0);
    check({name, " mem_image"}, 64'(merr), 64'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  // With poke set, start is re-asserted while busy and during DONE.
  task automatic run_transfer(input logic d, input logic [3:0] x,
                              input logic [11:0] base, input logic poke,
                              input string name);
    int n;
    int k;
    logic [63:0] e;
    logic [63:0] m;
    start     = 1'b1;
    dir       = d;
    last_reg  = x;
    base_addr = base;
    @(negedge cpu_clk);
    // Scramble the operands so any use of them after the start edge shows up.
    start     = 1'b0;
    dir       = ~d;
    last_reg  = ~x;
    base_addr = ~base;
    n = d ? int'(x) + 3 : int'(x) + 2;
    for (int c = 1; c <= n; c++) begin
      k = c - 1;
      m = '1;
      if (c == n) begin
        e = pack(0, 1, 0, 0, 4'd0, 8'd0, 12'd0, 8'd0);
      end else if (!d) begin
        e = pack(1, 0, 0, 1, 4'(k), 8'd0, addr(base, k), exp_regs[k]);
        m &= ~M_RD;
      end else if (c <= int'(x) + 1) begin
        if (k == 0) begin
          e = pack(1, 0, 0, 0, 4'd0, 8'd0, addr(base, 0), 8'd0);
          m &= ~(M_RA | M_RD | M_MD);
        end else begin
          e = pack(1, 0, 1, 0, 4'(k - 1), exp_mem[addr(base, k - 1)],
                   addr(base, k), 8'd0);
          m &= ~M_MD;
        end
      end else begin
        e = pack(1, 0, 1, 0, x, exp_mem[addr(base, int'(x))], 12'd0, 8'd0);
        m &= ~(M_MA | M_MD);
      end
      check($sformatf("%s cyc%0d", name, c), dut_bus() & m, e & m);
`ifdef CHIP8_I_INCREMENT_EN
      check($sformatf("%s i_upd cyc%0d", name, c), {51'd0, i_update, i_new},
            (c == n) ? {51'd0, 1'b1, addr(base, int'(x) + 1)} : 64'd0);
`endif
      start = poke && (c == 1 || c == n);
      @(negedge cpu_clk);
    end
    check({name, " idle1"}, dut_bus(), 64'd0);
    start = 1'b0;
    @(negedge cpu_clk);
    check({name, " idle2"}, dut_bus(), 64'd0);
    for (int i = 0; i <= int'(x); i++) begin
      if (!d) exp_mem[addr(base, i)] = exp_regs[i];
      else    exp_regs[i] = exp_mem[addr(base, i)];
    end
    compare_images(name);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    dir       = 1'b0;
    last_reg  = 4'd0;
    base_addr = 12'd0;
    load_img  = 1'b1;
    for (int i = 0; i < 4096; i++) img_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) img_regs[i] = 8'($urandom);
    img_regs[0] = 8'h11; img_regs[1] = 8'h22; img_regs[2] = 8'h33; img_regs[3] = 8'h44;
    img_mem[12'h200] = 8'hAA; img_mem[12'h201] = 8'hBB; img_mem[12'h202] = 8'hCC;
    for (int i = 0; i < 4096; i++) exp_mem[i] = img_mem[i];
    for (int i = 0; i < 16; i++) exp_regs[i] = img_regs[i];

    @(posedge cpu_clk);
    #1 load_img = 1'b0;
    check("reset outputs", dut_bus(), 64'd0);
`ifdef CHIP8_I_INCREMENT_EN
    check("reset i_update", {51'd0, i_update, i_new}, 64'd0);
`endif

    // Start on the very first edge after reset release.
    @(negedge cpu_clk);
    reset_n = 1'b1;
    run_transfer(1'b0, 4'd3, 12'h300, 1'b0, "store_x3");
    check("store_bytes", {32'd0, mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]},
          64'h1122_3344);

    run_transfer(1'b1, 4'd2, 12'h200, 1'b0, "load_x2");
    check("load_bytes", {40'd0, regs[0], regs[1], regs[2]}, 64'hAA_BBCC);

    run_transfer(1'b0, 4'd1, 12'hFFF, 1'b0, "wrap_store");
    run_transfer(1'b1, 4'd3, 12'hFFE, 1'b0, "wrap_load");
    run_transfer(1'b1, 4'd0, 12'(($urandom)), 1'b0, "load_x0");
    run_transfer(1'b0, 4'd15, 12'(($urandom)), 1'b0, "store_x15");
    run_transfer(1'b1, 4'd15, 12'(($urandom)), 1'b0, "load_x15");

    // Abort: reset during cycle 3 of an x=7 store. The writes at the ends of
    // cycles 1 and 2 stand; nothing else happens and no done pulse appears.
    start = 1'b1; dir = 1'b0; last_reg = 4'd7; base_addr = 12'h123;
    @(negedge cpu_clk);
    start = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    reset_n = 1'b0;
    #1 check("abort outputs", dut_bus(), 64'd0);
    exp_mem[addr(12'h123, 0)] = exp_regs[0];
    exp_mem[addr(12'h123, 1)] = exp_regs[1];
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      check($sformatf("abort hold%0d", i), dut_bus(), 64'd0);
    end
    reset_n = 1'b1;
    @(negedge cpu_clk);
    check("abort no done", dut_bus(), 64'd0);
    compare_images("abort");
    run_transfer(1'b0, 4'd2, 12'h050, 1'b0, "after_abort");

    // Starts pulsed while busy and during DONE are dropped.
    run_transfer(1'b0, 4'd3, 12'h300, 1'b1, "ignore_store");
    run_transfer(1'b1, 4'd4, 12'h7F0, 1'b1, "ignore_load");

    for (int t = 0; t < 12; t++) begin
      run_transfer(1'($urandom), 4'($urandom), 12'($urandom), 1'($urandom),
                   $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
